// File: rtl/fpu_sub_dispatch.sv
// Request queue and single-issue sequencer for the 3-cycle FP subtract unit.
// Optional FPU_SUB_DISPATCH_FTZ_EN flushes zero-exponent operands to signed zero at issue.
module fpu_sub_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic [31:0]                req_x1,
    input  logic [31:0]                req_x2,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [31:0]                res_y,
    output logic                       fu_en,
    output logic [31:0]                fu_x1,
    output logic [31:0]                fu_x2,
    input  logic [31:0]                fu_y,
    input  logic                       fu_valid,
    input  logic                       fu_idle,
    output logic                       err_timeout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int WD_W  = $clog2(TIMEOUT+1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [WD_W-1:0]    wd_cnt;
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [31:0]        x1_mem  [DEPTH];
    logic [31:0]        x2_mem  [DEPTH];
    logic [TAG_W-1:0]   tag_lat;
    logic               push, pop, load, capture, wd_fire, wd_hit;

    function automatic logic [31:0] ftz(input logic [31:0] v);
`ifdef FPU_SUB_DISPATCH_FTZ_EN
        return (v[30:23] == 8'd0) ? {v[31], 31'd0} : v;
`else
        return v;
`endif
    endfunction

    assign req_ready = (count < CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign wd_hit    = (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    // The watchdog is checked before fu_idle so a unit that never starts still times out.
    always_comb begin
        state_next = state;
        fu_en      = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        wd_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0 && !res_valid && fu_idle) begin
                    state_next = S_ISSUE;
                    load       = 1'b1;
                end
            end
            S_ISSUE: begin
                fu_en      = 1'b1;
                pop        = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                if (wd_hit) begin
                    wd_fire    = 1'b1;
                    state_next = S_IDLE;
                end else if (!fu_idle) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (fu_valid && fu_idle) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else if (wd_hit) begin
                    wd_fire    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            res_valid   <= 1'b0;
            res_y       <= '0;
            res_tag     <= '0;
            fu_x1       <= '0;
            fu_x2       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (state == S_ISSUE)
                wd_cnt <= '0;
            else if (state == S_BUSY || state == S_DONE)
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_fire) err_timeout <= 1'b1;

            if (capture) begin
                res_valid <= 1'b1;
                res_y     <= fu_y;
                res_tag   <= tag_lat;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            // Operands go out one cycle ahead so they are valid alongside fu_en.
            if (load) begin
                fu_x1 <= ftz(x1_mem[rd_ptr]);
                fu_x2 <= ftz(x2_mem[rd_ptr]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= req_tag;
            x1_mem[wr_ptr]  <= req_x1;
            x2_mem[wr_ptr]  <= req_x2;
        end
        if (load) tag_lat <= tag_mem[rd_ptr];
    end

endmodule
